// File: rtl/mdu_pkg.sv
// Shared definitions for the Multiply-Division Unit: funct3 opcodes,
// opcode field helpers and the result-conditioning state type.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, FIX, OUT} state_t;

  function automatic logic isDiv(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic divUnsigned(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic isRem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic mulHigh(input logic [2:0] op);
    return op[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate, modulo 2^PAR.
module cond_negate #(
  parameter int PAR = 32
) (
  input  logic           neg,
  input  logic [PAR-1:0] value,
  output logic [PAR-1:0] conditioned
);

  always_comb begin
    conditioned = value;
    if (neg) conditioned = '0 - value;
  end

endmodule

// File: rtl/result_conditioning.sv
// Output-side conditioning of the MDU: launches the iterative core and applies
// RISC-V M-extension result rules before presenting the result under valid/ready.
module result_conditioning
  import mdu_pkg::*;
#(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    startValid,
  output logic                    startReady,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR-1:0]          operand0,
  input  logic [PAR-1:0]          operand1,
  output logic                    coreStart,
  input  logic                    coreDone,
  input  logic [PAR-1:0]          coreHi,
  input  logic [PAR-1:0]          coreLo,
  output logic                    resultValid,
  input  logic                    resultReady,
  output logic [PAR-1:0]          result
);

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] opReg;
  logic                    negQ, negR, divZero, ovf;
  logic [PAR-1:0]          op1Reg, hiReg, loReg;
  logic [PAR-1:0]          quotient, remainder, fixValue;
  logic [2:0]              opIn, opSel;
  logic                    signedDivIn, divZeroIn, ovfIn;

  assign opIn  = opCode[2:0];
  assign opSel = opReg[2:0];

  assign signedDivIn = isDiv(opIn) && !divUnsigned(opIn);
  assign divZeroIn   = isDiv(opIn) && (operand0 == '0);
  assign ovfIn       = signedDivIn && (operand1 == {1'b1, {(PAR-1){1'b0}}}) && (operand0 == '1);

  assign startReady  = (state == IDLE);
  assign resultValid = (state == OUT);

  cond_negate #(.PAR(PAR)) quotientNeg (
    .neg         (negQ),
    .value       (loReg),
    .conditioned (quotient)
  );

  cond_negate #(.PAR(PAR)) remainderNeg (
    .neg         (negR),
    .value       (hiReg),
    .conditioned (remainder)
  );

  always_comb begin
    fixValue = '0;
    if (!isDiv(opSel))
      fixValue = mulHigh(opSel) ? hiReg : loReg;
    else if (divZero)
      fixValue = isRem(opSel) ? op1Reg : '1;
    else if (ovf)
      fixValue = isRem(opSel) ? '0 : {1'b1, {(PAR-1){1'b0}}};
    else
      fixValue = isRem(opSel) ? remainder : quotient;
  end

  // coreStart is high exactly in the first WAIT cycle, so it also serves as
  // the flag that masks coreDone in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      coreStart <= 1'b0;
      result    <= '0;
      opReg     <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divZero   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      coreStart <= 1'b0;
      case (state)
        IDLE: if (startValid) begin
          opReg   <= opCode;
          negQ    <= signedDivIn && (operand0[PAR-1] ^ operand1[PAR-1]);
          negR    <= signedDivIn && operand1[PAR-1];
          divZero <= divZeroIn;
          ovf     <= ovfIn;
          op1Reg  <= operand1;
          if (divZeroIn || ovfIn) begin
            state <= FIX;
          end else begin
            state     <= WAIT;
            coreStart <= 1'b1;
          end
        end
        WAIT: if (coreDone && !coreStart) begin
          hiReg <= coreHi;
          loReg <= coreLo;
          state <= FIX;
        end
        FIX: begin
          result <= fixValue;
          state  <= OUT;
        end
        OUT: if (resultReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_conditioning.sv
// Directed bench for result_conditioning with hand-computed expected results.
module tb_result_conditioning;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, startValid, startReady, coreStart, coreDone, resultValid, resultReady;
  logic [2:0]  opCode;
  logic [31:0] operand0, operand1, coreHi, coreLo, result;
  int          checks = 0;
  int          errors = 0;

  result_conditioning #(.PAR(32), .OPCODE_WIDTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .startValid  (startValid),
    .startReady  (startReady),
    .opCode      (opCode),
    .operand0    (operand0),
    .operand1    (operand1),
    .coreStart   (coreStart),
    .coreDone    (coreDone),
    .coreHi      (coreHi),
    .coreLo      (coreLo),
    .resultValid (resultValid),
    .resultReady (resultReady),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Normal operation: stray coreDone in the first WAIT cycle, real one after
  // 'extra' further WAIT cycles, result held for 'hold' cycles before accept.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] op1,
                       input logic [31:0] op0, input logic [31:0] hi, input logic [31:0] lo,
                       input int extra, input int hold, input logic [31:0] exp);
    check({tag, ".ready"}, {31'b0, startReady}, 32'd1);
    startValid = 1'b1; opCode = op; operand1 = op1; operand0 = op0;
    step();
    startValid = 1'b0; operand0 = 32'h0; operand1 = 32'h0;
    check({tag, ".start"}, {31'b0, coreStart}, 32'd1);
    check({tag, ".busy"}, {31'b0, startReady}, 32'd0);
    coreDone = 1'b1; coreHi = 32'hDEADBEEF; coreLo = 32'hCAFEF00D;
    step();
    coreDone = 1'b0;
    check({tag, ".startPulse"}, {31'b0, coreStart}, 32'd0);
    for (int i = 0; i < extra; i++) step();
    coreDone = 1'b1; coreHi = hi; coreLo = lo;
    step();
    coreDone = 1'b0; coreHi = 32'h0; coreLo = 32'h0;
    check({tag, ".fixValid"}, {31'b0, resultValid}, 32'd0);
    step();
    check({tag, ".valid"}, {31'b0, resultValid}, 32'd1);
    check({tag, ".result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      coreDone = (i == 2); coreHi = 32'h11111111; coreLo = 32'h22222222;
      step();
      coreDone = 1'b0;
      check({tag, ".holdValid"}, {31'b0, resultValid}, 32'd1);
      check({tag, ".holdResult"}, result, exp);
      check({tag, ".holdBusy"}, {31'b0, startReady}, 32'd0);
    end
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    check({tag, ".drop"}, {31'b0, resultValid}, 32'd0);
  endtask

  // Divide-by-zero / overflow: no core launch, resultValid two cycles after accept.
  task automatic runSpecial(input string tag, input logic [2:0] op, input logic [31:0] op1,
                            input logic [31:0] op0, input logic [31:0] exp);
    check({tag, ".ready"}, {31'b0, startReady}, 32'd1);
    startValid = 1'b1; opCode = op; operand1 = op1; operand0 = op0;
    step();
    startValid = 1'b0;
    check({tag, ".noStart1"}, {31'b0, coreStart}, 32'd0);
    check({tag, ".notYet"}, {31'b0, resultValid}, 32'd0);
    step();
    check({tag, ".noStart2"}, {31'b0, coreStart}, 32'd0);
    check({tag, ".valid"}, {31'b0, resultValid}, 32'd1);
    check({tag, ".result"}, result, exp);
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    check({tag, ".drop"}, {31'b0, resultValid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; startValid = 1'b0; opCode = OP_MUL; operand0 = '0; operand1 = '0;
    coreDone = 1'b0; coreHi = '0; coreLo = '0; resultReady = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst.ready", {31'b0, startReady}, 32'd1);
    check("rst.start", {31'b0, coreStart}, 32'd0);
    check("rst.valid", {31'b0, resultValid}, 32'd0);
    check("rst.result", result, 32'd0);

    runOp("mul",    OP_MUL,    32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 32'hFFFFFFEB);
    runOp("mulh",   OP_MULH,   32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1, 0, 32'hFFFFFFFF);
    runOp("mulhsu", OP_MULHSU, 32'd7, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 0, 0, 32'h00000006);
    runOp("mulhu",  OP_MULHU,  32'd7, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 2, 0, 32'h00000006);
    runOp("div",    OP_DIV,    32'hFFFFFFF9, 32'd2, 32'd1, 32'd3, 0, 0, 32'hFFFFFFFD);
    runOp("rem",    OP_REM,    32'hFFFFFFF9, 32'd2, 32'd1, 32'd3, 0, 0, 32'hFFFFFFFF);
    runOp("divu",   OP_DIVU,   32'hFFFFFFF9, 32'd2, 32'd1, 32'd3, 0, 0, 32'h00000003);
    runOp("remu",   OP_REMU,   32'hFFFFFFF9, 32'd2, 32'd1, 32'd3, 0, 0, 32'h00000001);
    runOp("divNN",  OP_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd1, 32'd3, 0, 0, 32'h00000003);
    runOp("remNN",  OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd1, 32'd3, 0, 0, 32'hFFFFFFFF);

    runSpecial("divu0", OP_DIVU, 32'h00001234, 32'h0, 32'hFFFFFFFF);
    runSpecial("remu0", OP_REMU, 32'h00001234, 32'h0, 32'h00001234);
    runSpecial("div0",  OP_DIV,  32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF);
    runSpecial("rem0",  OP_REM,  32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9);
    runSpecial("divOv", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    runSpecial("remOv", OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    runOp("bp",     OP_DIV, 32'd100, 32'hFFFFFFF6, 32'd0, 32'd10, 0, 5, 32'hFFFFFFF6);
    runOp("postBp", OP_MUL, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0, 32'd42);

    startValid = 1'b1; opCode = OP_MUL; operand1 = 32'd9; operand0 = 32'd9;
    step();
    startValid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    coreDone = 1'b1; coreHi = 32'h0; coreLo = 32'd81;
    step();
    coreDone = 1'b0;
    check("wrst.ready", {31'b0, startReady}, 32'd1);
    check("wrst.start", {31'b0, coreStart}, 32'd0);
    step();
    check("wrst.valid", {31'b0, resultValid}, 32'd0);
    check("wrst.result", result, 32'd0);
    runOp("postRst", OP_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 0, 0, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
